// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared opcode constants, ALUop encodings, FSM states and the
// registered EX/MEM bundle used by the execute stage.
package ex_stage_pkg;

    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;
    localparam logic [10:0] OPC_MUL = 11'b10011011000;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_PASSB = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_NONE  = 2'b11
    } aluOp_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } exState_t;

    typedef struct packed {
        logic        isBranch;
        logic        memRead;
        logic        memWrite;
        logic        regWrite;
        logic        memToReg;
        logic [4:0]  writeReg;
        logic [63:0] aluResult;
        logic [63:0] storeData;
        logic [63:0] branchTarget;
    } exOut_t;

    function automatic logic isMulOp(input logic [1:0] aluOp, input logic [10:0] aluControl);
        return (aluOp == ALUOP_RTYPE) && (aluControl == OPC_MUL);
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX inputs, EX/MEM outputs and the busy/flush handshake of
// the execute stage. master = surrounding pipeline, slave = ex_stage.
interface ex_stage_if;

    logic        flush_in;
    logic [1:0]  ALUop_in;
    logic        ALUsrc_in;
    logic        isBranch_in;
    logic        memRead_in;
    logic        memWrite_in;
    logic        regWrite_in;
    logic        memToReg_in;
    logic [63:0] programCounter_in;
    logic [63:0] regData1_in;
    logic [63:0] regData2_in;
    logic [63:0] signExtend_in;
    logic [10:0] ALUcontrol_in;
    logic [4:0]  writeReg_in;

    logic        busy_out;

    logic        isBranch_out;
    logic        memRead_out;
    logic        memWrite_out;
    logic        regWrite_out;
    logic        memToReg_out;
    logic        zero_out;
    logic [63:0] ALUresult_out;
    logic [63:0] storeData_out;
    logic [63:0] branchTarget_out;
    logic [4:0]  writeReg_out;

    modport master (
        output flush_in, ALUop_in, ALUsrc_in, isBranch_in, memRead_in, memWrite_in,
               regWrite_in, memToReg_in, programCounter_in, regData1_in, regData2_in,
               signExtend_in, ALUcontrol_in, writeReg_in,
        input  busy_out, isBranch_out, memRead_out, memWrite_out, regWrite_out,
               memToReg_out, zero_out, ALUresult_out, storeData_out, branchTarget_out,
               writeReg_out
    );

    modport slave (
        input  flush_in, ALUop_in, ALUsrc_in, isBranch_in, memRead_in, memWrite_in,
               regWrite_in, memToReg_in, programCounter_in, regData1_in, regData2_in,
               signExtend_in, ALUcontrol_in, writeReg_in,
        output busy_out, isBranch_out, memRead_out, memWrite_out, regWrite_out,
               memToReg_out, zero_out, ALUresult_out, storeData_out, branchTarget_out,
               writeReg_out
    );

endinterface

// File: rtl/ex_stage_seq_multiplier.sv
// seq_multiplier: radix-2 shift-add multiplier, one multiplier bit per step.
// product/done are combinational so the final bit is folded in on the same
// edge that the owner registers the result (count == 63).
module seq_multiplier (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        start,
    input  logic        step,
    input  logic [63:0] multiplicand,
    input  logic [63:0] multiplier,
    output logic        done,
    output logic [63:0] product
);

    logic [63:0] acc;
    logic [63:0] mcand;
    logic [63:0] mplier;
    logic [63:0] partial;
    logic [5:0]  count;

    assign partial = mplier[0] ? mcand : '0;
    assign product = acc + partial;
    assign done    = (count == 6'd63);

    // Load operands on start, then accumulate one shifted partial product per step
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= multiplicand;
            mplier <= multiplier;
            count  <= '0;
        end else if (step) begin
            acc    <= acc + partial;
            mcand  <= {mcand[62:0], 1'b0};
            mplier <= {1'b0, mplier[63:1]};
            count  <= count + 6'd1;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage (ALU, branch target, EX/MEM register).
// Build option EX_MUL_EN: when defined, MUL runs on an iterative 64-step
// multiplier behind a two-state FSM and stalls upstream via busy_out; when
// undefined, MUL decodes as unsupported (result 0) and busy_out is tied low.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic      CLOCK,
    input  logic      RESET,
    ex_stage_if.slave bus
);

    logic [63:0] opB;
    exOut_t      liveOut;
    exOut_t      nextOut;
    logic        bubble;

    // Operand select, single-cycle ALU and pass-through fields
    always_comb begin
        opB = bus.ALUsrc_in ? bus.signExtend_in : bus.regData2_in;
        liveOut.aluResult = '0;
        case (bus.ALUop_in)
            ALUOP_ADD:   liveOut.aluResult = bus.regData1_in + opB;
            ALUOP_PASSB: liveOut.aluResult = opB;
            ALUOP_RTYPE: begin
                case (bus.ALUcontrol_in)
                    OPC_ADD: liveOut.aluResult = bus.regData1_in + opB;
                    OPC_SUB: liveOut.aluResult = bus.regData1_in - opB;
                    OPC_AND: liveOut.aluResult = bus.regData1_in & opB;
                    OPC_ORR: liveOut.aluResult = bus.regData1_in | opB;
                    default: liveOut.aluResult = '0;
                endcase
            end
            default:     liveOut.aluResult = '0;
        endcase
        liveOut.isBranch     = bus.isBranch_in;
        liveOut.memRead      = bus.memRead_in;
        liveOut.memWrite     = bus.memWrite_in;
        liveOut.regWrite     = bus.regWrite_in;
        liveOut.memToReg     = bus.memToReg_in;
        liveOut.writeReg     = bus.writeReg_in;
        liveOut.storeData    = bus.regData2_in;
        liveOut.branchTarget = bus.programCounter_in + {bus.signExtend_in[61:0], 2'b00};
    end

`ifdef EX_MUL_EN
    exState_t    state;
    exState_t    stateNext;
    logic        mulDecoded;
    logic        mulStart;
    logic        mulStep;
    logic        mulDone;
    logic        fsmBubble;
    logic        useProduct;
    logic        busy;
    logic [63:0] mulProduct;
    exOut_t      held;

    assign mulDecoded = isMulOp(bus.ALUop_in, bus.ALUcontrol_in);

    // FSM state register
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) state <= ST_IDLE;
        else       state <= stateNext;
    end

    // Next state, multiplier control and busy; flush always wins over MUL
    always_comb begin
        stateNext  = state;
        mulStart   = 1'b0;
        mulStep    = 1'b0;
        fsmBubble  = 1'b0;
        useProduct = 1'b0;
        busy       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mulDecoded && !bus.flush_in) begin
                    stateNext = ST_MUL;
                    mulStart  = 1'b1;
                    fsmBubble = 1'b1;
                    busy      = 1'b1;
                end
            end
            ST_MUL: begin
                busy = !mulDone;
                if (bus.flush_in) begin
                    stateNext = ST_IDLE;
                    fsmBubble = 1'b1;
                end else if (mulDone) begin
                    stateNext  = ST_IDLE;
                    mulStep    = 1'b1;
                    useProduct = 1'b1;
                end else begin
                    mulStep   = 1'b1;
                    fsmBubble = 1'b1;
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    // Hold the MUL's controls so the product leaves with them
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET)         held <= '0;
        else if (mulStart) held <= liveOut;
    end

    seq_multiplier uMul (
        .CLOCK        (CLOCK),
        .RESET        (RESET),
        .start        (mulStart),
        .step         (mulStep),
        .multiplicand (bus.regData1_in),
        .multiplier   (opB),
        .done         (mulDone),
        .product      (mulProduct)
    );

    assign bus.busy_out = busy;
    assign bubble       = bus.flush_in || fsmBubble;
`else
    assign bus.busy_out = 1'b0;
    assign bubble       = bus.flush_in;
`endif

    // Choose what the EX/MEM register captures: live ALU, finished product or bubble
    always_comb begin
        nextOut = liveOut;
`ifdef EX_MUL_EN
        if (useProduct) begin
            nextOut           = held;
            nextOut.aluResult = mulProduct;
        end
`endif
        if (bubble) nextOut = '0;
    end

    // EX/MEM pipeline register
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            bus.isBranch_out     <= 1'b0;
            bus.memRead_out      <= 1'b0;
            bus.memWrite_out     <= 1'b0;
            bus.regWrite_out     <= 1'b0;
            bus.memToReg_out     <= 1'b0;
            bus.zero_out         <= 1'b0;
            bus.writeReg_out     <= '0;
            bus.ALUresult_out    <= '0;
            bus.storeData_out    <= '0;
            bus.branchTarget_out <= '0;
        end else begin
            bus.isBranch_out     <= nextOut.isBranch;
            bus.memRead_out      <= nextOut.memRead;
            bus.memWrite_out     <= nextOut.memWrite;
            bus.regWrite_out     <= nextOut.regWrite;
            bus.memToReg_out     <= nextOut.memToReg;
            bus.zero_out         <= (nextOut.aluResult == '0);
            bus.writeReg_out     <= nextOut.writeReg;
            bus.ALUresult_out    <= nextOut.aluResult;
            bus.storeData_out    <= nextOut.storeData;
            bus.branchTarget_out <= nextOut.branchTarget;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: scoreboard bench for ex_stage. The driver pushes the expected
// EX/MEM contents for every edge; a monitor pops and compares after each edge.
// Honours EX_MUL_EN the same way the design does.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic CLOCK = 1'b0;
    logic RESET = 1'b0;

    ex_stage_if bus ();

    ex_stage dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLOCK = ~CLOCK;

    // ctl bits: {isBranch, memRead, memWrite, regWrite, memToReg}
    typedef struct {
        logic        flush;
        logic [1:0]  aluOp;
        logic        aluSrc;
        logic [4:0]  ctl;
        logic [10:0] aluCtrl;
        logic [4:0]  wr;
        logic [63:0] pc;
        logic [63:0] rd1;
        logic [63:0] rd2;
        logic [63:0] se;
    } stim_t;

    typedef struct {
        logic        bubble;
        logic [4:0]  ctl;
        logic [4:0]  wr;
        logic [63:0] res;
        logic [63:0] store;
        logic [63:0] target;
        logic        zero;
    } exp_t;

    exp_t        sbq[$];
    int unsigned checks   = 0;
    int unsigned failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference behaviour straight from the operation table
    function automatic exp_t model(input stim_t s);
        exp_t        e;
        logic [63:0] b;
        logic [63:0] r;
        b = s.aluSrc ? s.se : s.rd2;
        r = 64'd0;
        if (s.aluOp == 2'b00) r = s.rd1 + b;
        else if (s.aluOp == 2'b01) r = b;
        else if (s.aluOp == 2'b10) begin
            if (s.aluCtrl == OPC_ADD) r = s.rd1 + b;
            else if (s.aluCtrl == OPC_SUB) r = s.rd1 - b;
            else if (s.aluCtrl == OPC_AND) r = s.rd1 & b;
            else if (s.aluCtrl == OPC_ORR) r = s.rd1 | b;
`ifdef EX_MUL_EN
            else if (s.aluCtrl == OPC_MUL) r = s.rd1 * b;
`endif
        end
        e.bubble = 1'b0;
        e.ctl    = s.ctl;
        e.wr     = s.wr;
        e.res    = r;
        e.store  = s.rd2;
        e.target = s.pc + s.se * 64'd4;
        e.zero   = (r == 64'd0);
        return e;
    endfunction

    function automatic exp_t bubbleExp();
        exp_t e;
        e = '{bubble: 1'b1, ctl: 5'd0, wr: 5'd0, res: 64'd0, store: 64'd0, target: 64'd0, zero: 1'b0};
        return e;
    endfunction

    function automatic logic [63:0] rnd64();
        if ($urandom_range(0, 3) == 0) return 64'($urandom_range(0, 15));
        return {$urandom, $urandom};
    endfunction

    function automatic stim_t randomStim();
        stim_t s;
        s.flush  = 1'b0;
        s.aluOp  = 2'($urandom_range(0, 3));
        s.aluSrc = 1'($urandom);
        s.ctl    = 5'($urandom);
        s.wr     = 5'($urandom);
        case ($urandom_range(0, 5))
            0:       s.aluCtrl = OPC_ADD;
            1:       s.aluCtrl = OPC_SUB;
            2:       s.aluCtrl = OPC_AND;
            3:       s.aluCtrl = OPC_ORR;
            4:       s.aluCtrl = OPC_MUL;
            default: s.aluCtrl = 11'($urandom);
        endcase
        s.pc  = {$urandom, $urandom};
        s.rd1 = rnd64();
        s.rd2 = rnd64();
        s.se  = rnd64();
        if ($urandom_range(0, 7) == 0) s.rd2 = s.rd1;
        return s;
    endfunction

    function automatic stim_t mk(input logic [1:0] aluOp, input logic aluSrc, input logic [10:0] aluCtrl,
                                 input logic [4:0] ctl, input logic [63:0] rd1, input logic [63:0] rd2,
                                 input logic [63:0] se, input logic [63:0] pc, input logic [4:0] wr);
        stim_t s;
        s.flush = 1'b0; s.aluOp = aluOp; s.aluSrc = aluSrc; s.aluCtrl = aluCtrl; s.ctl = ctl;
        s.rd1 = rd1; s.rd2 = rd2; s.se = se; s.pc = pc; s.wr = wr;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        bus.flush_in          = s.flush;
        bus.ALUop_in          = s.aluOp;
        bus.ALUsrc_in         = s.aluSrc;
        bus.isBranch_in       = s.ctl[4];
        bus.memRead_in        = s.ctl[3];
        bus.memWrite_in       = s.ctl[2];
        bus.regWrite_in       = s.ctl[1];
        bus.memToReg_in       = s.ctl[0];
        bus.ALUcontrol_in     = s.aluCtrl;
        bus.writeReg_in       = s.wr;
        bus.programCounter_in = s.pc;
        bus.regData1_in       = s.rd1;
        bus.regData2_in       = s.rd2;
        bus.signExtend_in     = s.se;
    endtask

    task automatic checkAllZero(input string tag);
        chk({tag, "_ctl"}, 64'({bus.isBranch_out, bus.memRead_out, bus.memWrite_out,
                                bus.regWrite_out, bus.memToReg_out}), 64'd0);
        chk({tag, "_zero_wr"}, 64'({bus.zero_out, bus.writeReg_out}), 64'd0);
        chk({tag, "_result"}, bus.ALUresult_out, 64'd0);
        chk({tag, "_store"}, bus.storeData_out, 64'd0);
        chk({tag, "_target"}, bus.branchTarget_out, 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy_out), 64'd0);
    endtask

    // Issue one instruction starting at a negedge; a MUL occupies 65 edges
    // (64 bubbles then the product) unless flushed at counter value flushAt.
    task automatic runOp(input stim_t s, input int flushAt);
        stim_t j;
        drive(s);
        #1;
        if (s.flush) begin
            chk("busy_flush", 64'(bus.busy_out), 64'd0);
            sbq.push_back(bubbleExp());
            @(negedge CLOCK);
            return;
        end
`ifdef EX_MUL_EN
        if (s.aluOp == 2'b10 && s.aluCtrl == OPC_MUL) begin
            chk("busy_mul_start", 64'(bus.busy_out), 64'd1);
            sbq.push_back(bubbleExp());
            @(negedge CLOCK);
            for (int c = 0; c < 64; c++) begin
                j = randomStim();
                j.flush = (c == flushAt);
                drive(j);
                #1;
                if (c == 63) begin
                    chk("busy_mul_last", 64'(bus.busy_out), 64'd0);
                    sbq.push_back(model(s));
                end else begin
                    chk("busy_mul_run", 64'(bus.busy_out), 64'd1);
                    sbq.push_back(bubbleExp());
                end
                @(negedge CLOCK);
                if (c == flushAt) return;
            end
            return;
        end
`endif
        chk("busy_single", 64'(bus.busy_out), 64'd0);
        sbq.push_back(model(s));
        @(negedge CLOCK);
    endtask

    // Monitor: compare the EX/MEM register after every edge that has an expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge CLOCK);
            #1;
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                if (e.bubble) begin
                    chk("bubble_ctl", 64'({bus.isBranch_out, bus.memRead_out, bus.memWrite_out,
                                           bus.regWrite_out, bus.memToReg_out}), 64'd0);
                end else begin
                    chk("ctl", 64'({bus.isBranch_out, bus.memRead_out, bus.memWrite_out,
                                    bus.regWrite_out, bus.memToReg_out}), 64'(e.ctl));
                    chk("writeReg", 64'(bus.writeReg_out), 64'(e.wr));
                    chk("ALUresult", bus.ALUresult_out, e.res);
                    chk("zero", 64'(bus.zero_out), 64'(e.zero));
                    chk("storeData", bus.storeData_out, e.store);
                    chk("branchTarget", bus.branchTarget_out, e.target);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    // Driver
    initial begin
        stim_t s;
        stim_t idle;
        int    fa;
        idle = mk(2'b00, 1'b0, 11'd0, 5'd0, 64'd0, 64'd0, 64'd0, 64'd0, 5'd0);
        drive(idle);
        #2;
        RESET = 1'b1;
        #1;
        checkAllZero("reset");
        @(negedge CLOCK);
        RESET = 1'b0;

        // R-type ADD 5 + 7
        runOp(mk(2'b10, 1'b0, OPC_ADD, 5'b00010, 64'd5, 64'd7, 64'd0, 64'h1000, 5'd3), -1);
        // SUB 9 - 9 -> zero
        runOp(mk(2'b10, 1'b0, OPC_SUB, 5'b00010, 64'd9, 64'd9, 64'd2, 64'h2000, 5'd4), -1);
        // Pass B with regData2 = 0, branch
        runOp(mk(2'b01, 1'b0, OPC_AND, 5'b10000, 64'd33, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h80, 5'd0), -1);
        // Load: 0x100 + 8, target 0x40 + 32
        runOp(mk(2'b00, 1'b1, 11'd0, 5'b01011, 64'h100, 64'h55, 64'd8, 64'h40, 5'd9), -1);
        // AND / ORR / unsupported / ALUop 11
        runOp(mk(2'b10, 1'b0, OPC_AND, 5'b00010, 64'hF0F0, 64'hFF00, 64'd1, 64'd0, 5'd1), -1);
        runOp(mk(2'b10, 1'b1, OPC_ORR, 5'b00010, 64'hF0F0, 64'd0, 64'h0F0F, 64'd4, 5'd2), -1);
        runOp(mk(2'b10, 1'b0, 11'h7FF, 5'b00110, 64'd3, 64'd4, 64'd0, 64'd0, 5'd5), -1);
        runOp(mk(2'b11, 1'b0, OPC_ADD, 5'b00010, 64'd3, 64'd4, 64'd0, 64'd0, 5'd6), -1);
        // MUL 0xFFFFFFFF * 3
        runOp(mk(2'b10, 1'b0, OPC_MUL, 5'b00010, 64'hFFFF_FFFF, 64'd3, 64'd0, 64'h300, 5'd7), -1);
        // MUL aborted by flush at counter 10, then a plain ADD right after
        runOp(mk(2'b10, 1'b0, OPC_MUL, 5'b00010, 64'd123, 64'd456, 64'd0, 64'h400, 5'd8), 10);
        runOp(mk(2'b10, 1'b0, OPC_ADD, 5'b00010, 64'd20, 64'd22, 64'd0, 64'h404, 5'd8), -1);
        // Flush coinciding with a MUL decode, and flush of an ordinary op
        s = mk(2'b10, 1'b0, OPC_MUL, 5'b00010, 64'd5, 64'd6, 64'd0, 64'd0, 5'd1);
        s.flush = 1'b1;
        runOp(s, -1);
        s = mk(2'b00, 1'b0, 11'd0, 5'b11111, 64'd1, 64'd2, 64'd0, 64'd0, 5'd31);
        s.flush = 1'b1;
        runOp(s, -1);
        // Wrap-around arithmetic
        runOp(mk(2'b00, 1'b0, 11'd0, 5'b00010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0, 5'd2), -1);
        runOp(mk(2'b10, 1'b0, OPC_SUB, 5'b00010, 64'd0, 64'd1, 64'd0, 64'd0, 5'd2), -1);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            s = randomStim();
            if ($urandom_range(0, 9) == 0) s.flush = 1'b1;
            fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 62)) : -1;
            runOp(s, fa);
        end

        // Reset in the middle of a multiply
`ifdef EX_MUL_EN
        s = mk(2'b10, 1'b0, OPC_MUL, 5'b00010, 64'd77, 64'd88, 64'd0, 64'h500, 5'd12);
        drive(s);
        #1;
        chk("busy_mul_start", 64'(bus.busy_out), 64'd1);
        sbq.push_back(bubbleExp());
        @(negedge CLOCK);
        for (int c = 0; c < 30; c++) begin
            drive(randomStim());
            #1;
            chk("busy_mul_run", 64'(bus.busy_out), 64'd1);
            sbq.push_back(bubbleExp());
            @(negedge CLOCK);
        end
`endif
        drive(idle);
        #2;
        RESET = 1'b1;
        #1;
        checkAllZero("midreset");
        @(negedge CLOCK);
        RESET = 1'b0;
        runOp(mk(2'b10, 1'b0, OPC_ADD, 5'b00010, 64'd1, 64'd1, 64'd0, 64'h600, 5'd13), -1);

        // Trailing flushed cycles expose any stray result from the discarded multiply
        for (int n = 0; n < 70; n++) begin
            s = idle;
            s.flush = 1'b1;
            runOp(s, -1);
        end
        chk("queue_drained", 64'(sbq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL expose: CLOCK  in  1  pipeline clock, rising edge.
REQ-002 SHALL expose: RESET  in  1  asynchronous, active-high reset.
REQ-003 SHALL expose: flush_in  in  1  squash the instruction presented this cycle (taken branch).
REQ-004 SHALL expose ID/EX-side inputs:
  - ALUop_in  2
  - ALUsrc_in  1
  - isBranch_in, memRead_in, memWrite_in, regWrite_in, memToReg_in  1 each
  - programCounter_in, regData1_in, regData2_in, signExtend_in  64 each
  - ALUcontrol_in  11
  - writeReg_in  5
REQ-005 SHALL expose: busy_out  out  1  combinational; high means upstream SHALL hold its register contents.
REQ-006 SHALL expose registered EX/MEM-side outputs:
  - isBranch_out, memRead_out, memWrite_out, regWrite_out, memToReg_out, zero_out  1 each
  - ALUresult_out, storeData_out, branchTarget_out  64 each
  - writeReg_out  5

Function
REQ-007 Operand B SHALL be signExtend_in when ALUsrc_in=1, else regData2_in.
REQ-008 Operation decode SHALL be:
  - ALUop 00: ADD.
  - ALUop 01: PASS B.
  - ALUop 10: decode ALUcontrol_in:
    - 10001011000 ADD
    - 11001011000 SUB
    - 10001010000 AND
    - 10101010000 ORR
    - 10011011000 MUL
    - any other value: result 0
  - ALUop 11: result 0.
REQ-009 Arithmetic SHALL be 64-bit modulo 2^64; MUL SHALL return the low 64 bits of the product.
REQ-010 zero_out SHALL be 1 when the registered result equals 0.
REQ-011 branchTarget_out SHALL be programCounter_in + (signExtend_in << 2), truncated to 64 bits.
REQ-012 storeData_out SHALL be regData2_in; all other control and writeReg outputs SHALL pass through unchanged.
REQ-013 Non-MUL operations SHALL have 1-cycle latency: outputs update on the next rising edge, and busy_out=0.
REQ-014 The FSM SHALL have two states:
  - IDLE: combinational ALU path.
  - MUL: radix-2 shift-add multiply with a 6-bit iteration counter.
REQ-015 IDLE to MUL transition:
  - Occurs on a decoded MUL with flush_in=0.
  - On that edge: latch operands and controls, clear the counter.
  - In the same edge: drive a bubble (all control outputs 0).
REQ-016 MUL state, each edge:
  - Process one multiplier bit and increment the counter.
  - Drive a bubble every cycle until the counter equals 63.
REQ-017 At the edge with counter=63, the block SHALL register the product with the latched controls and return to IDLE.
REQ-018 busy_out SHALL equal (IDLE AND decoded MUL AND NOT flush_in) OR (MUL AND counter≠63), giving exactly 64 busy cycles per MUL.
REQ-019 flush_in=1 in IDLE SHALL register a bubble (controls 0; data outputs don't-care but deterministic).
REQ-020 flush_in=1 in MUL SHALL abort the multiply, register a bubble, and return to IDLE.
REQ-021 When flush_in and a MUL decode coincide, flush SHALL win: no multiply starts and busy_out stays 0.
REQ-022 Inputs presented while in MUL SHALL be ignored except flush_in; upstream holds them via busy_out.

Reset
REQ-023 RESET=1 SHALL asynchronously force state to IDLE, counter to 0, and every registered output to 0; busy_out SHALL then be 0.
REQ-024 Reset during MUL SHALL discard the partial product; no result SHALL emerge after release.
REQ-025 The first edge after reset release SHALL process inputs normally.

Configuration
REQ-026 Macro EX_MUL_EN SHALL control the multiplier:
  - Defined: MUL FSM and iterative multiplier are built as above.
  - Undefined: MUL opcode SHALL decode as unsupported (result 0, 1-cycle latency), busy_out SHALL be tied to 0, and no FSM or multiplier logic SHALL exist.

Structure
REQ-027 A shared package SHALL hold:
  - the 11-bit opcode constants (ADD, SUB, AND, ORR, MUL)
  - the ALUop encodings
  - the FSM state enum
REQ-028 The iterative multiplier SHALL be a sub-module named seq_multiplier (start, operands, done, product), instantiated only under EX_MUL_EN.

Verification
REQ-029 R-type ADD, regData1=5, regData2=7 -> after 1 edge: ALUresult_out=12, zero_out=0, busy_out=0 throughout.
REQ-030 SUB, regData1=9, regData2=9 -> ALUresult_out=0, zero_out=1; ALUop 01 with regData2=0 and isBranch_in=1 -> isBranch_out=1, zero_out=1.
REQ-031 Load with ALUop 00, ALUsrc=1, regData1=0x100, signExtend=8, PC=0x40 -> ALUresult_out=0x108, branchTarget_out=0x60, memRead_out=1.
REQ-032 MUL 0xFFFFFFFF × 0x3 (EX_MUL_EN defined) -> busy_out high for 64 cycles with bubbles out; 65th edge gives ALUresult_out=0x2FFFFFFFD, regWrite_out=1.
REQ-033 MUL started, then flush_in=1 at counter=10 -> bubble registered, IDLE next cycle, busy_out=0, no result ever emitted.
REQ-034 RESET asserted mid-MUL at counter=30 -> all outputs 0 immediately; after release, ADD 1+1 yields 2 after one edge.
